// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration-side AHB signal bundle: requests and transfer status in, grant and
// address-phase ownership out.
interface ahb_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [IDX_W-1:0]       HMASTER;
  logic                   HMASTLOCK;

  // Requesting/bus side.
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  // Arbiter side.
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with default-master parking, locked transfers and
// a per-tenure hold limit; every state change is qualified by HREADY.
module ahb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD       = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_bus_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_MASTERS);
  localparam int unsigned HOLD_W = 5;

  localparam logic [IDX_W-1:0]  DEF_IDX     = IDX_W'(DEFAULT_MASTER);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(MAX_HOLD - 1);
  localparam logic [1:0]        HTRANS_BUSY = 2'd1;
  localparam logic [1:0]        HTRANS_SEQ  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       owner_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [HOLD_W-1:0]      hold_q;
  logic [IDX_W-1:0]       hmaster_q;
  logic                   hmastlock_q;

  logic [NUM_MASTERS-1:0] lock_req;
  logic [NUM_MASTERS-1:0] other_req;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   in_burst;
  logic                   hold_done;
  logic                   arb_now;
  logic                   rr_found;
  logic [IDX_W-1:0]       rr_winner;
  logic [IDX_W-1:0]       rr_cand;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // A lock request only counts when the same master is also requesting.
  assign lock_req   = bus.HBUSREQ & bus.HLOCK;
  assign other_req  = bus.HBUSREQ & ~grant_q;
  assign owner_req  = bus.HBUSREQ[owner_q];
  assign owner_lock = lock_req[owner_q];
  assign in_burst   = (bus.HTRANS == HTRANS_SEQ) || (bus.HTRANS == HTRANS_BUSY);

  // Tenure is up only at a burst boundary and only if someone else is waiting.
  assign hold_done  = (hold_q == HOLD_LAST) && (|other_req) && !in_burst;

  // First requester found scanning upward from the master after the last owner.
  always_comb begin : rr_search
    rr_found  = 1'b0;
    rr_winner = ptr_q;
    rr_cand   = ptr_q;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      rr_cand = IDX_W'((32'(ptr_q) + k) % NUM_MASTERS);
      if (!rr_found && bus.HBUSREQ[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  always_comb begin : arb_decision
    arb_now = 1'b0;
    case (state_q)
      ST_IDLE:  arb_now = 1'b1;
      ST_OWNED: arb_now = !owner_req || hold_done;
      default:  arb_now = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin : fsm
    if (HRESET) begin
      state_q     <= ST_IDLE;
      grant_q     <= onehot(DEF_IDX);
      owner_q     <= DEF_IDX;
      ptr_q       <= DEF_IDX;
      hold_q      <= '0;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else if (bus.HREADY) begin
      // Address phase trails the grant by one completed transfer.
      hmaster_q   <= owner_q;
      hmastlock_q <= owner_lock;
      if (arb_now && rr_found) begin
        grant_q <= onehot(rr_winner);
        owner_q <= rr_winner;
        ptr_q   <= rr_winner;
        hold_q  <= '0;
        state_q <= lock_req[rr_winner] ? ST_LOCKED : ST_OWNED;
      end else if (arb_now) begin
        grant_q <= onehot(DEF_IDX);
        owner_q <= DEF_IDX;
        hold_q  <= '0;
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_OWNED: begin
            if (hold_q != HOLD_LAST) begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
          ST_LOCKED: begin
            // Keep the grant through the last locked data phase; the locked
            // tenure already used up its share, so hand over at the next boundary.
            if (!owner_lock) begin
              state_q <= ST_OWNED;
              hold_q  <= HOLD_LAST;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: a tenure-level reference model checked every
// cycle, plus hand-computed grant/master sequences for the key scenarios.
module tb_ahb_bus_arbiter;

  localparam int NM  = 4;
  localparam int DEF = 0;
  localparam int MH  = 4;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  ahb_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS    (NM),
    .DEFAULT_MASTER (DEF),
    .MAX_HOLD       (MH)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk_g(input string name, input logic [3:0] exp);
    vectors++;
    if (bus.HGRANT !== exp) begin
      miscompares++;
      $display("FAIL %s HGRANT got %b want %b at %0t", name, bus.HGRANT, exp, $time);
    end
  endtask

  task automatic chk_m(input string name, input logic [1:0] exp);
    vectors++;
    if (bus.HMASTER !== exp) begin
      miscompares++;
      $display("FAIL %s HMASTER got %0d want %0d at %0t", name, bus.HMASTER, exp, $time);
    end
  endtask

  task automatic chk_l(input string name, input logic exp);
    vectors++;
    if (bus.HMASTLOCK !== exp) begin
      miscompares++;
      $display("FAIL %s HMASTLOCK got %b want %b at %0t", name, bus.HMASTLOCK, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how long they have held it, and whether
  // their turn is protected by a lock.
  int m_owner    = DEF;
  int m_last     = DEF;
  int m_tenure   = 0;
  int m_hmaster  = DEF;
  bit m_parked   = 1'b1;
  bit m_locked   = 1'b0;
  bit m_spent    = 1'b0;
  bit m_hmastlock = 1'b0;

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'b0001) != 4'b0000;
  endfunction

  function automatic int rr_pick(input logic [3:0] req);
    for (int k = 1; k <= NM; k++) begin
      if (bit_of(req, (m_last + k) % NM)) return (m_last + k) % NM;
    end
    return m_last;
  endfunction

  task automatic model_reset();
    m_owner = DEF; m_last = DEF; m_tenure = 0; m_hmaster = DEF;
    m_parked = 1'b1; m_locked = 1'b0; m_spent = 1'b0; m_hmastlock = 1'b0;
  endtask

  task automatic model_take(input int w, input logic [3:0] lreq);
    m_owner = w; m_last = w; m_parked = 1'b0;
    m_locked = bit_of(lreq, w); m_tenure = 0; m_spent = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] req, input logic [3:0] lock,
                            input logic [1:0] trans, input logic ready);
    bit others, expired, burst;
    if (ready) begin
      m_hmaster   = m_owner;
      m_hmastlock = bit_of(req & lock, m_owner);
      if (m_parked) begin
        if (req != 4'b0000) model_take(rr_pick(req), req & lock);
      end else if (m_locked) begin
        if (!bit_of(req & lock, m_owner)) begin
          m_locked = 1'b0;
          m_spent  = 1'b1;
        end
      end else begin
        others  = (req & ~4'(1 << m_owner)) != 4'b0000;
        expired = m_spent || (m_tenure >= MH - 1);
        burst   = (trans == 2'd3) || (trans == 2'd1);
        if (!bit_of(req, m_owner) || (expired && others && !burst)) begin
          if (req != 4'b0000) begin
            model_take(rr_pick(req), req & lock);
          end else begin
            m_owner = DEF; m_parked = 1'b1; m_locked = 1'b0;
            m_tenure = 0; m_spent = 1'b0;
          end
        end else begin
          m_tenure++;
        end
      end
    end
  endtask

  // Every clock edge and every reset rise: advance the model, then compare.
  always begin : compare
    logic [3:0] s_req, s_lock;
    logic [1:0] s_trans;
    logic       s_ready, s_rst;
    @(posedge HCLK or posedge HRESET);
    s_req = bus.HBUSREQ; s_lock = bus.HLOCK; s_trans = bus.HTRANS;
    s_ready = bus.HREADY; s_rst = HRESET;
    #1;
    if (s_rst) model_reset();
    else       model_step(s_req, s_lock, s_trans, s_ready);
    chk_g("model_grant", 4'(1 << m_owner));
    chk_m("model_hmaster", 2'(m_hmaster));
    chk_l("model_hmastlock", m_hmastlock);
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] rr_gnt [12];
  logic [1:0] rr_hm  [12];
  logic [3:0] frz_req [5];

  initial begin : stim
    rr_gnt  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    rr_hm   = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    frz_req = '{4'b0110, 4'b0010, 4'b0000, 4'b1111, 4'b0100};

    bus.HBUSREQ = 4'b0000;
    bus.HLOCK   = 4'b0000;
    bus.HTRANS  = 2'd0;
    bus.HREADY  = 1'b1;

    // Reset values, then parking on the default master.
    repeat (3) @(negedge HCLK);
    chk_g("reset_grant", 4'b0001);
    chk_m("reset_hmaster", 2'd0);
    chk_l("reset_hmastlock", 1'b0);
    HRESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      chk_g("park_grant", 4'b0001);
      chk_m("park_hmaster", 2'd0);
      chk_l("park_hmastlock", 1'b0);
    end

    // Two requesters alternate every MAX_HOLD cycles.
    bus.HBUSREQ = 4'b0110;
    bus.HTRANS  = 2'd2;
    for (int i = 0; i < 12; i++) begin
      @(negedge HCLK);
      chk_g("rr_pair_grant", rr_gnt[i]);
      chk_m("rr_pair_hmaster", rr_hm[i]);
    end

    // Master 2 wins and locks; nobody else gets in for 40 cycles.
    bus.HBUSREQ = 4'b1111;
    bus.HLOCK   = 4'b0100;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      chk_g("locked_grant", 4'b0100);
      if (i > 0) chk_l("locked_hmastlock", 1'b1);
    end
    bus.HLOCK = 4'b0000;
    @(negedge HCLK);
    chk_g("unlock_tail_grant", 4'b0100);
    chk_m("unlock_tail_hmaster", 2'd2);
    chk_l("unlock_tail_hmastlock", 1'b0);
    @(negedge HCLK);
    chk_g("unlock_handover_grant", 4'b1000);
    @(negedge HCLK);
    chk_m("unlock_handover_hmaster", 2'd3);

    // Hold limit reached mid-burst: no handover until a burst boundary.
    bus.HBUSREQ = 4'b1001;
    bus.HTRANS  = 2'd3;
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      chk_g("seq_hold_grant", 4'b1000);
    end
    bus.HTRANS = 2'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      chk_g("busy_hold_grant", 4'b1000);
    end
    bus.HTRANS = 2'd2;
    @(negedge HCLK);
    chk_g("burst_end_grant", 4'b0001);
    chk_m("burst_end_hmaster", 2'd3);

    // HREADY low freezes everything while requests churn.
    bus.HREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.HBUSREQ = frz_req[i];
      @(negedge HCLK);
      chk_g("frozen_grant", 4'b0001);
      chk_m("frozen_hmaster", 2'd3);
      chk_l("frozen_hmastlock", 1'b0);
    end
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    chk_g("resume_grant", 4'b0100);
    chk_m("resume_hmaster", 2'd0);

    // Park, then enter a locked tenure for master 2.
    bus.HBUSREQ = 4'b0000;
    @(negedge HCLK);
    chk_g("drop_park_grant", 4'b0001);
    chk_m("drop_park_hmaster", 2'd2);
    bus.HBUSREQ = 4'b0100;
    bus.HLOCK   = 4'b0100;
    @(negedge HCLK);
    chk_g("relock_grant", 4'b0100);
    @(negedge HCLK);
    chk_m("relock_hmaster", 2'd2);
    chk_l("relock_hmastlock", 1'b1);

    // Reset pulse between clock edges while locked, released with HREADY low.
    bus.HREADY = 1'b0;
    #1 HRESET = 1'b1;
    #2;
    chk_g("pulse_grant", 4'b0001);
    chk_m("pulse_hmaster", 2'd0);
    chk_l("pulse_hmastlock", 1'b0);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk_g("post_reset_stall_grant", 4'b0001);
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    chk_g("post_reset_arb_grant", 4'b0100);
    chk_m("post_reset_arb_hmaster", 2'd0);
    chk_l("post_reset_arb_hmastlock", 1'b0);
    @(negedge HCLK);
    chk_l("post_reset_lock_hmastlock", 1'b1);

    // Everyone requests unlocked: rotation checked by the model.
    bus.HLOCK   = 4'b0000;
    bus.HBUSREQ = 4'b1111;
    repeat (24) @(negedge HCLK);
    bus.HBUSREQ = 4'b0000;
    repeat (3) @(negedge HCLK);
    chk_g("final_park_grant", 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
